fp_add_arb: RTL

//  Shares one pipelined fp_add instance between N_REQ requesters. Round-robin picks at most one op per cycle.

---
 rtl/fp_add_arb_pkg.sv | 18 +
 rtl/fp_add_arb_if.sv | 28 ++
 rtl/fp_add_arb_rr_arbiter.sv | 51 +++++
 rtl/fp_add_arb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fp_add_arb_pkg.sv
// fp_add_arb_pkg: constants and helpers shared by the fp_add sharing logic.
//   FP_ADD_LAT : fp_add normal-path latency, start to done (cycles)
//   op_kind_e  : class of an issued op (normal path / special fast path)
//   idx_w()    : index width for an N-entry one-hot vector (at least 1)
package fp_add_arb_pkg;

  localparam int FP_ADD_LAT = 5;

  typedef enum logic {
    OP_NORMAL  = 1'b0,
    OP_SPECIAL = 1'b1
  } op_kind_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_add_arb_if.sv
// fp_add_arb_if: client-side bundle between requesters and fp_add_arb.
//   req_valid[N_REQ]        per-requester op valid
//   req_ready[N_REQ]        one-hot grant; op accepted when valid&ready
//   req_op_a/b[N_REQ*DATA_W] operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid[N_REQ]        one-hot 1-cycle result strobe, no backpressure
//   rsp_res[DATA_W]         result, valid with any rsp_valid bit
// Modports: master = requester side, slave = arbiter side.
interface fp_add_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_op_a;
  logic [N_REQ*DATA_W-1:0] req_op_b;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_res;

  modport master (
    output req_valid, req_op_a, req_op_b,
    input  req_ready, rsp_valid, rsp_res
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    output req_ready, rsp_valid, rsp_res
  );
endinterface

// File: rtl/fp_add_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker with a registered pointer.
//   clk, rst  clock, synchronous active-high reset (pointer -> 0)
//   req[N]    eligible requests
//   advance   a grant was taken this cycle; pointer moves past the winner
//   grant[N]  one-hot grant, first request at or after the pointer
//   win       index of the granted requester (valid when grant != 0)
module rr_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] win
);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;
  logic          found;

  // Scan N positions starting at ptr; cand wraps manually so N need not
  // be a power of two.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    if (found) grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PW'(N-1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_arb.sv
// fp_add_arb: shares one pipelined fp_add between N_REQ requesters.
// One op per cycle is picked round-robin and launched straight into fp_add.
// A shadow schedule mirrors fp_add's completion timing so every done is
// routed back to its issuer and no two ops are due in the same cycle.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cli (slave)           requester handshake and result bundle
//   fpu_start/op_a/op_b   launch into fp_add (same cycle as the grant)
//   fpu_done/fpu_res      completion from fp_add
//   err_seq               sticky: a scheduled result had no fpu_done
//   stat_issued/stall     only with FP_ADD_ARB_STATS_EN: accepted ops and
//                         cycles with a request pending but nothing issued
module fp_add_arb
  import fp_add_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int LAT    = FP_ADD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_arb_if.slave       cli,
  output logic              fpu_start,
  output logic [DATA_W-1:0] fpu_op_a,
  output logic [DATA_W-1:0] fpu_op_b,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_res,
  output logic              err_seq
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
`endif
);

  localparam int TW = idx_w(N_REQ);

  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tag;
  } slot_t;

  slot_t [LAT-1:0]   sched;
  logic [N_REQ-1:0]  special;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [TW-1:0]     win;
  logic              issue;
  logic              hazard;
  op_kind_e          kind;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_res_q;
  logic              err_q;

  // An op takes fp_add's fast path when either exponent field is all ones.
  always_comb begin
    special = '0;
    for (int i = 0; i < N_REQ; i++) begin
      special[i] = (&cli.req_op_a[i*DATA_W + DATA_W-2 -: EXP_W]) |
                   (&cli.req_op_b[i*DATA_W + DATA_W-2 -: EXP_W]);
    end
  end

  // sched[1] shifts into slot 0 next cycle, exactly where a special issued
  // now would land, so specials are held off while it is busy.
  assign hazard   = sched[1].vld;
  assign eligible = cli.req_valid & ~(special & {N_REQ{hazard}}) & {N_REQ{~rst}};

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (issue),
    .grant   (grant),
    .win     (win)
  );

  assign issue = |grant;
  assign kind  = (issue && special[win]) ? OP_SPECIAL : OP_NORMAL;

  always_comb begin
    fpu_op_a = '0;
    fpu_op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        fpu_op_a = cli.req_op_a[i*DATA_W +: DATA_W];
        fpu_op_b = cli.req_op_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign fpu_start = issue;

  // Slot 0 is the op whose done is due this cycle. Specials go straight to
  // slot 0 (due next cycle); their normal-path phantom done later meets an
  // empty head and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sched       <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int k = 0; k < LAT-1; k++) sched[k] <= sched[k+1];
      sched[LAT-1] <= '0;
      if (issue) begin
        if (kind == OP_SPECIAL) sched[0]     <= '{vld: 1'b1, tag: win};
        else                    sched[LAT-1] <= '{vld: 1'b1, tag: win};
      end
      rsp_valid_q <= '0;
      if (sched[0].vld) begin
        if (fpu_done) begin
          rsp_valid_q[sched[0].tag] <= 1'b1;
          rsp_res_q                 <= fpu_res;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cli.req_ready = grant;
  assign cli.rsp_valid = rsp_valid_q;
  assign cli.rsp_res   = rsp_res_q;
  assign err_seq       = err_q;

`ifdef FP_ADD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue) stat_issued <= stat_issued + 32'd1;
      if ((|cli.req_valid) && !issue) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
